// File: rtl/trig_coax_pkg.sv
// Shared types and constants for the coax trigger link, used by both the
// front-end transmitter and the receiver-side code.
package trig_coax_pkg;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_GUARD,
    ST_SYNC,
    ST_DONE
  } state_t;

  localparam int FRAME_LEN       = 4;
  localparam int SLOT_PHASE      = 0;
  localparam int DEF_GUARD_TICKS = 210;
  localparam int DEF_NPULSE      = 54;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level, synchronous reset to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/trig_coax_tx.sv
// Coax trigger-link transmitter: slot-aligned trigger pulses in RUN, a muted
// guard period and a phase-aligned sync burst during the calibration window.
// Define TRIG_COAX_TX_COUNT_EN to add the tx_count / drop_count statistics.
module trig_coax_tx
  import trig_coax_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int GUARD_TICKS = DEF_GUARD_TICKS,
  parameter int NPULSE      = DEF_NPULSE
) (
  input  logic             i_clk_adc,
  input  logic             i_reset,
  input  logic [NCH-1:0]   i_trig_in,
  input  logic             i_sync_window,
  output logic [NCH-1:0]   o_coax_out,
  output logic             o_tx_muted,
  output logic             o_sync_sent
`ifdef TRIG_COAX_TX_COUNT_EN
  ,
  output logic [NCH*16-1:0] o_tx_count,
  output logic [15:0]       o_drop_count
`endif
);

  localparam int GW = $clog2(GUARD_TICKS + 1);
  localparam int FW = $clog2(FRAME_LEN);

  state_t         r_state;
  state_t         w_state_next;
  logic [FW-1:0]  r_frame;
  logic [NCH-1:0] r_pending;
  logic [NCH-1:0] w_pending_next;
  logic [NCH-1:0] r_coax;
  logic [NCH-1:0] w_coax_next;
  logic [GW-1:0]  r_guard_cnt;
  logic [GW-1:0]  w_guard_next;
  logic [6:0]     r_pulse_cnt;
  logic [6:0]     w_pulse_next;
  logic           r_sync_sent;
  logic           w_sync_sent_next;
  logic           w_win_sync;
  logic           r_win_prev;
  logic           w_win_rise;
  logic           w_win_fall;
  logic           w_slot;

  sync_2ff u_sync_win (
    .i_clk   (i_clk_adc),
    .i_reset (i_reset),
    .i_d     (i_sync_window),
    .o_q     (w_win_sync)
  );

  assign w_win_rise = w_win_sync & ~r_win_prev;
  assign w_win_fall = ~w_win_sync & r_win_prev;
  assign w_slot     = (r_frame == FW'(SLOT_PHASE));

  always_ff @(posedge i_clk_adc) begin
    if (i_reset) r_state <= ST_RUN;
    else         r_state <= w_state_next;
  end

  // Every emission is decided here and registered below, so coax_out lags the slot by one cycle.
  always_comb begin
    w_state_next     = r_state;
    w_pending_next   = r_pending;
    w_coax_next      = '0;
    w_guard_next     = r_guard_cnt;
    w_pulse_next     = r_pulse_cnt;
    w_sync_sent_next = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_slot) begin
          w_coax_next    = r_pending | i_trig_in;
          w_pending_next = '0;
        end else begin
          w_pending_next = r_pending | i_trig_in;
        end
        if (w_win_rise) begin
          w_state_next   = ST_GUARD;
          w_pending_next = '0;
          w_guard_next   = '0;
        end
      end
      ST_GUARD: begin
        w_pending_next = '0;
        if (w_win_fall) begin
          w_state_next = ST_RUN;
          w_guard_next = '0;
        end else if (r_guard_cnt == GW'(GUARD_TICKS - 1)) begin
          w_state_next = ST_SYNC;
          w_guard_next = '0;
          w_pulse_next = '0;
        end else begin
          w_guard_next = r_guard_cnt + GW'(1);
        end
      end
      ST_SYNC: begin
        w_pending_next = '0;
        if (w_win_fall) begin
          w_state_next = ST_RUN;
          w_pulse_next = '0;
        end else if (w_slot) begin
          w_coax_next  = '1;
          w_pulse_next = r_pulse_cnt + 7'd1;
          if (w_pulse_next == 7'(NPULSE)) begin
            w_state_next     = ST_DONE;
            w_sync_sent_next = 1'b1;
            w_pulse_next     = '0;
          end
        end
      end
      ST_DONE: begin
        w_pending_next = '0;
        if (w_win_fall) w_state_next = ST_RUN;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk_adc) begin
    if (i_reset) begin
      r_frame     <= '0;
      r_pending   <= '0;
      r_coax      <= '0;
      r_guard_cnt <= '0;
      r_pulse_cnt <= '0;
      r_sync_sent <= 1'b0;
      r_win_prev  <= 1'b0;
    end else begin
      r_frame     <= r_frame + FW'(1);
      r_pending   <= w_pending_next;
      r_coax      <= w_coax_next;
      r_guard_cnt <= w_guard_next;
      r_pulse_cnt <= w_pulse_next;
      r_sync_sent <= w_sync_sent_next;
      r_win_prev  <= w_win_sync;
    end
  end

  assign o_coax_out  = r_coax;
  assign o_sync_sent = r_sync_sent;
  assign o_tx_muted  = (r_state != ST_RUN);

`ifdef TRIG_COAX_TX_COUNT_EN
  logic [NCH-1:0][15:0] r_tx_count;
  logic [15:0]          r_drop_count;

  // Only RUN-state trigger pulses count; sync pulses are excluded by the state test.
  always_ff @(posedge i_clk_adc) begin
    if (i_reset) begin
      r_tx_count   <= '0;
      r_drop_count <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (r_state == ST_RUN && w_coax_next[c] && r_tx_count[c] != 16'hFFFF)
          r_tx_count[c] <= r_tx_count[c] + 16'd1;
      end
      if (r_state != ST_RUN && (|i_trig_in) && r_drop_count != 16'hFFFF)
        r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign o_tx_count   = r_tx_count;
  assign o_drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_trig_coax_tx.sv
// Self-checking bench for trig_coax_tx: per-cycle comparison against a
// window/slot model plus directed scenarios with hand-computed expectations.
module tb_trig_coax_tx;

  localparam int NCH = 4;
  localparam int GUARD_TICKS = 210;
  localparam int NPULSE = 54;

  logic clk = 1'b0;
  logic reset;
  logic [NCH-1:0] trig;
  logic win;
  logic [NCH-1:0] coax;
  logic muted;
  logic sent;
`ifdef TRIG_COAX_TX_COUNT_EN
  logic [NCH*16-1:0] txCount;
  logic [15:0] dropCount;
`endif

  int vectors = 0;
  int misses = 0;

  always #5 clk = ~clk;

  trig_coax_tx #(.NCH(NCH), .GUARD_TICKS(GUARD_TICKS), .NPULSE(NPULSE)) dut (
    .i_clk_adc     (clk),
    .i_reset       (reset),
    .i_trig_in     (trig),
    .i_sync_window (win),
    .o_coax_out    (coax),
    .o_tx_muted    (muted),
    .o_sync_sent   (sent)
`ifdef TRIG_COAX_TX_COUNT_EN
    ,
    .o_tx_count    (txCount),
    .o_drop_count  (dropCount)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      misses++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] t, input logic w, input int cycles);
    trig = t;
    win = w;
    repeat (cycles) @(negedge clk);
  endtask

  // Model: a muting window opens two edges after the raw window changes and
  // sync slots are those more than GUARD_TICKS edges past the opening edge.
  logic [NCH-1:0] mPend, expCoax, sampTrig;
  bit mSw1, mSw2, mSwPrev, mMuted, expSent, winRise, winFall, slot;
  int mFrame, edgeCount, muteEdge, mPulses, mDrop;
  int mTx[NCH];

  always @(posedge clk) begin
    sampTrig = trig;
    if (reset) begin
      mSw1 = 0; mSw2 = 0; mSwPrev = 0; mMuted = 0;
      mPend = '0; expCoax = '0; expSent = 0;
      mFrame = 0; edgeCount = 0; muteEdge = 0; mPulses = 0; mDrop = 0;
      for (int c = 0; c < NCH; c++) mTx[c] = 0;
    end else begin
      winRise = mSw2 && !mSwPrev;
      winFall = !mSw2 && mSwPrev;
      mSwPrev = mSw2; mSw2 = mSw1; mSw1 = win;
      slot = (mFrame == 0);
      expCoax = '0;
      expSent = 0;
      if (mMuted && sampTrig != 0 && mDrop < 65535) mDrop++;
      if (!mMuted) begin
        if (slot) begin
          expCoax = mPend | sampTrig;
          mPend = '0;
        end else begin
          mPend = mPend | sampTrig;
        end
        for (int c = 0; c < NCH; c++) if (expCoax[c] && mTx[c] < 65535) mTx[c]++;
        if (winRise) begin
          mMuted = 1; muteEdge = edgeCount; mPulses = 0; mPend = '0;
        end
      end else if (winFall) begin
        mMuted = 0;
        mPend = '0;
      end else if (slot && (edgeCount - muteEdge) > GUARD_TICKS && mPulses < NPULSE) begin
        expCoax = '1;
        mPulses++;
        expSent = (mPulses == NPULSE);
      end
      mFrame = (mFrame + 1) % 4;
      edgeCount++;
    end
    #1;
    checkOutput("coax_out", 32'(coax), 32'(expCoax));
    checkOutput("tx_muted", 32'(muted), 32'(mMuted));
    checkOutput("sync_sent", 32'(sent), 32'(expSent));
`ifdef TRIG_COAX_TX_COUNT_EN
    for (int c = 0; c < NCH; c++) checkOutput("tx_count", 32'(txCount[c*16 +: 16]), 32'(mTx[c]));
    checkOutput("drop_count", 32'(dropCount), 32'(mDrop));
`endif
  end

  initial begin
    int hits[$];
    int mutedAt, pulses, sentCnt, sentBad, earlyOut, badFrame, gapBad, ch1Extra, lastPulse;
    int waitCnt, n, extra;
    bit found;

    reset = 1'b1; trig = '0; win = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_coax", 32'(coax), 32'h0);
    checkOutput("reset_muted", 32'(muted), 32'h0);
    checkOutput("reset_sent", 32'(sent), 32'h0);
    reset = 1'b0;

    // Single request on channel 2 sampled at frame 2 leaves at the next frame 1.
    applyStimulus(4'b0000, 1'b0, 2);
    applyStimulus(4'b0100, 1'b0, 1);
    applyStimulus(4'b0000, 1'b0, 1);
    checkOutput("t1_idle", 32'(coax), 32'h0);
    @(negedge clk);
    checkOutput("t1_pulse", 32'(coax), 32'h4);
    checkOutput("t1_frame", 32'(mFrame), 32'h1);
    @(negedge clk);
    checkOutput("t1_width", 32'(coax), 32'h0);

    // Held request for 12 cycles starting at frame 1 yields three pulses.
    for (int i = 0; i < 4 && mFrame != 1; i++) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      trig = (i < 12) ? 4'b0001 : 4'b0000;
      @(negedge clk);
      if (coax[0]) hits.push_back(i);
    end
    trig = '0;
    checkOutput("hold_count", 32'(hits.size()), 32'd3);
    if (hits.size() == 3) begin
      checkOutput("hold_first", 32'(hits[0]), 32'd3);
      checkOutput("hold_gap1", 32'(hits[1] - hits[0]), 32'd4);
      checkOutput("hold_gap2", 32'(hits[2] - hits[1]), 32'd4);
    end
    applyStimulus(4'b0000, 1'b0, 4);

    // Full calibration window with channel 1 requesting throughout the mute.
    mutedAt = -1; pulses = 0; sentCnt = 0; sentBad = 0; earlyOut = 0;
    badFrame = 0; gapBad = 0; ch1Extra = 0; lastPulse = -100;
    win = 1'b1;
    for (int i = 1; i <= 700; i++) begin
      @(negedge clk);
      if (i == 3) trig = 4'b0010;
      if (mutedAt < 0 && muted) mutedAt = i;
      if (coax != 0 && i <= 212) earlyOut++;
      if (coax == 4'b1111) begin
        pulses++;
        if (mFrame != 1) badFrame++;
        if (pulses > 1 && i - lastPulse != 4) gapBad++;
        lastPulse = i;
      end else if (coax != 0) begin
        ch1Extra++;
      end
      if (sent) begin
        sentCnt++;
        if (!(coax == 4'b1111 && pulses == NPULSE)) sentBad++;
      end
    end
    checkOutput("win_mute_delay", 32'(mutedAt), 32'd3);
    checkOutput("win_guard_quiet", 32'(earlyOut), 32'd0);
    checkOutput("win_pulses", 32'(pulses), 32'd54);
    checkOutput("win_pulse_frame", 32'(badFrame), 32'd0);
    checkOutput("win_pulse_gap", 32'(gapBad), 32'd0);
    checkOutput("win_trig_muted", 32'(ch1Extra), 32'd0);
    checkOutput("win_sent_count", 32'(sentCnt), 32'd1);
    checkOutput("win_sent_align", 32'(sentBad), 32'd0);
    checkOutput("win_done_muted", 32'(muted), 32'h1);

    win = 1'b0;
    found = 0; waitCnt = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      waitCnt = i;
      if (coax[1]) found = 1;
    end
    checkOutput("fall_trig_found", 32'(found), 32'h1);
    checkOutput("fall_trig_latency_le7", 32'(waitCnt <= 7), 32'h1);
    checkOutput("fall_trig_value", 32'(coax), 32'h2);
`ifdef TRIG_COAX_TX_COUNT_EN
    checkOutput("drop_nonzero", 32'(dropCount != 0), 32'h1);
    checkOutput("tx1_post_window", 32'(txCount[16 +: 16]), 32'd1);
`endif
    applyStimulus(4'b0000, 1'b0, 8);

    // Window dropped after the 20th sync pulse aborts the burst.
    n = 0; sentCnt = 0;
    win = 1'b1;
    for (int i = 0; i < 700 && n < 20; i++) begin
      @(negedge clk);
      if (coax == 4'b1111) n++;
      if (sent) sentCnt++;
    end
    checkOutput("abort_reach20", 32'(n), 32'd20);
    win = 1'b0;
    extra = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (coax == 4'b1111) extra++;
      if (sent) sentCnt++;
    end
    checkOutput("abort_no_more_sync", 32'(extra), 32'd0);
    checkOutput("abort_no_sent", 32'(sentCnt), 32'd0);
    checkOutput("abort_unmuted", 32'(muted), 32'h0);
    trig = 4'b1000;
    found = 0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      trig = '0;
      if (coax[3]) found = 1;
    end
    checkOutput("abort_trig_resumes", 32'(found), 32'h1);
    applyStimulus(4'b0000, 1'b0, 4);

    // Reset for one cycle in the middle of a burst.
    n = 0;
    win = 1'b1;
    for (int i = 0; i < 700 && n < 5; i++) begin
      @(negedge clk);
      if (coax == 4'b1111) n++;
    end
    checkOutput("rst_reach5", 32'(n), 32'd5);
    reset = 1'b1; win = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_coax", 32'(coax), 32'h0);
    checkOutput("rst_muted", 32'(muted), 32'h0);
    trig = 4'b0001;
    @(negedge clk);
    trig = '0;
    checkOutput("rst_frame_slot", 32'(coax), 32'h1);
    @(negedge clk);
    checkOutput("rst_after", 32'(coax), 32'h0);
    applyStimulus(4'b0000, 1'b0, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
